ttl_counter_n: RTL and testbench

- Parametrised synchronous presettable binary/modulo-N counter.
- Next-generation member of the TTL model library; generalises the 74161/74163/74191 family into one block.
- Configurable width, configurable modulus and optional up/down mode.
- Cascadable through 74163-style ENP/ENT/RCO, so wide counters and dividers can be built from identical instances.

---
 rtl/ttl_pkg.sv | 25 ++
 rtl/ttl_counter_n.sv | 78 +++++++
 tb/tb_ttl_counter_n.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL-style counter model library: direction
// encoding and a ceiling-log2 helper used for elaboration-time parameter checks.
package ttl_pkg;

    // Direction encoding on the D_U pin.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Ceiling log2 over a 64-bit value, so that 2**32 moduli are representable.
    // ttl_clog2(1) = 0, ttl_clog2(2) = 1, ttl_clog2(16) = 4, ttl_clog2(17) = 5.
    function automatic int unsigned ttl_clog2(input longint unsigned value);
        int unsigned     result;
        longint unsigned remain;
        result = 32'd0;
        remain = (value == 64'd0) ? 64'd0 : (value - 64'd1);
        for (int i = 0; i < 64; i++) begin
            if (remain != 64'd0) begin
                result = result + 32'd1;
            end
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage : ttl_pkg

// File: rtl/ttl_counter_n.sv
// Parametrised synchronous presettable modulo-N counter with optional up/down
// mode and 74163-style ENP/ENT/RCO cascading. Q is registered; RCO is a purely
// combinational function of Q, ENT and the effective direction so that a chain
// of identical instances advances on a single edge.
module ttl_counter_n #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH,
    parameter bit              DIR_EN  = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD_n,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             D_U,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);
    import ttl_pkg::*;

    // Highest legal count; both the up-wrap point and the down-wrap target.
    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_Q  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Reject widths outside 1..32 and moduli outside 2..2**WIDTH at elaboration.
    if ((WIDTH < 1) || (WIDTH > 32) || (MODULUS < 64'd2) ||
        (ttl_clog2(MODULUS) > WIDTH)) begin : g_bad_params
        $error("ttl_counter_n: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
    end

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_load_val;
    logic             w_dir;
    logic             w_tc;
    logic             w_load_in_range;

    // Up-only builds ignore the direction pin entirely.
    assign w_dir = DIR_EN ? D_U : DIR_UP;

    // Out-of-range load data clamps to the top of the count range.
    assign w_load_in_range = (64'(D) < MODULUS);
    assign w_load_val      = w_load_in_range ? D : MAX_Q;

    // Terminal count: last state before wrapping in the current direction.
    assign w_tc = (w_dir == DIR_DOWN) ? (r_q == ZERO_Q) : (r_q == MAX_Q);

    // Next-state selection: load beats count beats hold (reset handled in the register).
    always_comb begin
        w_q_next = r_q;
        if (LOAD_n == 1'b0) begin
            w_q_next = w_load_val;
        end else if ((ENP == 1'b1) && (ENT == 1'b1)) begin
            if (w_dir == DIR_DOWN) begin
                w_q_next = (r_q == ZERO_Q) ? MAX_Q : (r_q - ONE_Q);
            end else begin
                w_q_next = (r_q == MAX_Q) ? ZERO_Q : (r_q + ONE_Q);
            end
        end else begin
            w_q_next = r_q;
        end
    end

    // Count register with synchronous active-high reset taking top priority.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q <= ZERO_Q;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign Q   = r_q;
    assign RCO = ENT & w_tc;

endmodule : ttl_counter_n

// File: tb/tb_ttl_counter_n.sv
// Scoreboard bench for ttl_counter_n. Four instances share one set of controls:
//   dut_a : WIDTH=4, MODULUS=10, up/down
//   dut_c : WIDTH=4, MODULUS=7,  up-only (D_U ignored)
//   dut_lo/dut_hi : two WIDTH=4, MODULUS=16 stages cascaded into an 8-bit counter
// The driver pushes the expected visible state for each cycle; a monitor on
// the falling edge pops and compares.
module tb_ttl_counter_n;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_load_n = 1'b1;
    logic       i_enp = 1'b0;
    logic       i_ent = 1'b0;
    logic       i_d_u = 1'b0;
    logic [7:0] i_d = 8'h00;

    logic [3:0] qa, qc, qlo, qhi;
    logic       rcoa, rcoc, rcolo, rcohi;

    always #5 clk = ~clk;

    ttl_counter_n #(.WIDTH(4), .MODULUS(64'd10), .DIR_EN(1'b1)) dut_a (
        .CLK(clk), .RST(i_rst), .LOAD_n(i_load_n), .ENP(i_enp), .ENT(i_ent),
        .D_U(i_d_u), .D(i_d[3:0]), .Q(qa), .RCO(rcoa));

    ttl_counter_n #(.WIDTH(4), .MODULUS(64'd7), .DIR_EN(1'b0)) dut_c (
        .CLK(clk), .RST(i_rst), .LOAD_n(i_load_n), .ENP(i_enp), .ENT(i_ent),
        .D_U(i_d_u), .D(i_d[3:0]), .Q(qc), .RCO(rcoc));

    ttl_counter_n #(.WIDTH(4), .MODULUS(64'd16), .DIR_EN(1'b1)) dut_lo (
        .CLK(clk), .RST(i_rst), .LOAD_n(i_load_n), .ENP(i_enp), .ENT(i_ent),
        .D_U(i_d_u), .D(i_d[3:0]), .Q(qlo), .RCO(rcolo));

    ttl_counter_n #(.WIDTH(4), .MODULUS(64'd16), .DIR_EN(1'b1)) dut_hi (
        .CLK(clk), .RST(i_rst), .LOAD_n(i_load_n), .ENP(i_enp), .ENT(rcolo),
        .D_U(i_d_u), .D(i_d[7:4]), .Q(qhi), .RCO(rcohi));

    typedef struct {
        bit chk;
        int qa;
        bit rcoa;
        int qc;
        bit rcoc;
        int qv;
        bit rcov;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model state: plain integers in 0..M-1.
    int   ma = 0;
    int   mc = 0;
    int   mv = 0;
    bit   model_ok = 1'b0;

    // Compare one observed value against its expectation.
    task automatic check(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: the counter presents a new state every cycle; compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                check("a_q",   int'(qa), e.qa);
                check("a_rco", int'(rcoa), int'(e.rcoa));
                check("c_q",   int'(qc), e.qc);
                check("c_rco", int'(rcoc), int'(e.rcoc));
                check("cas_q", int'({qhi, qlo}), e.qv);
                check("cas_rco", int'(rcohi), int'(e.rcov));
            end
        end
    end

    // Apply one cycle of controls, record what must be visible during it,
    // then advance the model by the edge that ends the cycle.
    task automatic cycle(input bit rst, input bit ld_n, input bit enp,
                         input bit ent, input bit du, input bit [7:0] d);
        exp_t e;
        int   dl;
        @(posedge clk);
        #1;
        i_rst = rst; i_load_n = ld_n; i_enp = enp; i_ent = ent; i_d_u = du; i_d = d;
        e.chk  = model_ok;
        e.qa   = ma;
        e.rcoa = ent && (du ? (ma == 0) : (ma == 9));
        e.qc   = mc;
        e.rcoc = ent && (mc == 6);
        e.qv   = mv;
        e.rcov = ent && (du ? (mv == 0) : (mv == 255));
        sb.push_back(e);
        dl = int'(d[3:0]);
        if (rst) begin
            ma = 0; mc = 0; mv = 0;
            model_ok = 1'b1;
        end else if (!ld_n) begin
            ma = (dl < 10) ? dl : 9;
            mc = (dl < 7) ? dl : 6;
            mv = int'(d);
        end else if (enp && ent) begin
            ma = du ? (ma + 9) % 10 : (ma + 1) % 10;
            mc = (mc + 1) % 7;
            mv = du ? (mv + 255) % 256 : (mv + 1) % 256;
        end
    endtask

    initial begin
        int  b;
        bit  rst, ld_n, enp, ent, du;
        bit [7:0] d;

        cycle(1, 1, 0, 0, 0, 8'h00);
        // Reset beats load and enables, then the load lands.
        cycle(1, 0, 1, 1, 0, 8'h05);
        cycle(0, 0, 1, 1, 0, 8'h05);
        cycle(0, 1, 0, 0, 0, 8'h00);
        // Up wrap at 9, with ENT low suppressing RCO at the terminal count.
        cycle(0, 0, 0, 0, 0, 8'h08);
        cycle(0, 1, 1, 1, 0, 8'h00);
        cycle(0, 1, 1, 0, 0, 8'h00);
        cycle(0, 1, 1, 1, 0, 8'h00);
        cycle(0, 1, 1, 1, 0, 8'h00);
        cycle(0, 1, 1, 1, 0, 8'h00);
        // Down wrap from 1 and a direction flip at 8.
        cycle(0, 0, 0, 0, 1, 8'h01);
        cycle(0, 1, 1, 1, 1, 8'h00);
        cycle(0, 1, 1, 1, 1, 8'h00);
        cycle(0, 1, 1, 1, 1, 8'h00);
        cycle(0, 1, 1, 1, 0, 8'h00);
        cycle(0, 1, 1, 1, 0, 8'h00);
        // ENP low holds; out-of-range load clamps.
        cycle(0, 0, 1, 1, 0, 8'h03);
        repeat (4) cycle(0, 1, 0, 1, 0, 8'h00);
        cycle(0, 0, 1, 1, 0, 8'h0C);
        cycle(0, 1, 0, 0, 0, 8'h00);
        // Cascade carries: 0x0F -> 0x10 and 0xFF -> 0x00, plus down 0x00 -> 0xFF.
        cycle(0, 0, 0, 0, 0, 8'h0F);
        cycle(0, 1, 1, 1, 0, 8'h00);
        cycle(0, 0, 0, 0, 0, 8'hFF);
        cycle(0, 1, 1, 1, 0, 8'h00);
        cycle(0, 1, 1, 1, 1, 8'h00);
        cycle(0, 1, 0, 0, 0, 8'h00);
        // Up-only instance ignores D_U=1 out of reset.
        cycle(1, 1, 1, 1, 1, 8'h00);
        repeat (4) cycle(0, 1, 1, 1, 1, 8'h00);

        // Randomised traffic with biased control probabilities.
        du = 1'b0;
        for (int n = 0; n < 600; n++) begin
            b    = int'($urandom_range(0, 99));
            rst  = (b < 2);
            ld_n = !(int'($urandom_range(0, 99)) < 10);
            enp  = (int'($urandom_range(0, 99)) < 85);
            ent  = (int'($urandom_range(0, 99)) < 85);
            if (int'($urandom_range(0, 99)) < 8) begin
                du = ~du;
            end
            d    = 8'($urandom);
            cycle(rst, ld_n, enp, ent, du, d);
        end

        // Bounded drain of the scoreboard.
        for (int w = 0; w < 10; w++) begin
            if (sb.size() > 0) begin
                @(posedge clk);
            end
        end
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ttl_counter_n
